// File: rtl/prompt_decoder.sv
// prompt_decoder: decodes a packed string of unary codes (k ones then a zero, k=1..4) into a symbol stream
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, bstring        decode request (taken only in IDLE) and the packed string, oldest code at the MSB
//   sym_valid, sym        decoded symbol (1..4) held until sym_ready; sym reads 0 when no symbol is offered
//   sym_ready             consumer handshake, only looked at while a symbol is offered
//   busy                  high whenever the decoder is not idle
//   done, error           registered one-cycle pulses, raised the cycle after leaving DONE or ERR
//   count                 symbols accepted since the last start, saturating at 32
module prompt_decoder #(
    parameter int STRING_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [STRING_W-1:0] bstring,
    input  logic                sym_ready,
    output logic                sym_valid,
    output logic [2:0]          sym,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [5:0]          count
);
    localparam int RW = $clog2(STRING_W + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] PARSE = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    logic [2:0]          state;
    logic [STRING_W-1:0] shreg;
    logic [RW-1:0]       rem;
    logic [2:0]          ones;
    logic [2:0]          sym_q;
    logic                msb;

    assign msb       = shreg[STRING_W-1];
    assign sym_valid = state == EMIT;
    assign sym       = sym_valid ? sym_q : 3'd0;
    assign busy      = state != IDLE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            rem   <= '0;
            ones  <= '0;
            sym_q <= '0;
            count <= '0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done  <= state == DONE;
            error <= state == ERR;
            case (state)
                IDLE: if (start) begin
                    shreg <= bstring;
                    rem   <= RW'(STRING_W);
                    ones  <= '0;
                    count <= '0;
                    state <= ALIGN;
                end
                ALIGN: if (shreg == '0) begin
                    state <= DONE;
                end else if (!msb) begin
                    shreg <= shreg << 1;
                    rem   <= rem - RW'(1);
                end else begin
                    state <= PARSE;
                end
                // running out of bits before a terminating zero is a truncated code
                PARSE: if (rem == '0) begin
                    state <= ERR;
                end else if (msb) begin
                    if (ones == 3'd4) begin
                        state <= ERR;
                    end else begin
                        shreg <= shreg << 1;
                        rem   <= rem - RW'(1);
                        ones  <= ones + 3'd1;
                    end
                end else if (ones == 3'd0) begin
                    state <= ERR;
                end else begin
                    shreg <= shreg << 1;
                    rem   <= rem - RW'(1);
                    sym_q <= ones;
                    state <= EMIT;
                end
                EMIT: if (sym_ready) begin
                    count <= count == 6'd32 ? count : count + 6'd1;
                    ones  <= '0;
                    state <= shreg == '0 ? DONE : PARSE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prompt_decoder.sv
// tb_prompt_decoder: randomized and directed checks of prompt_decoder against a bit-walking reference model
module tb_prompt_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sym_ready = 1'b0;
    logic [63:0] bstring = '0;
    logic        sym_valid, busy, done, error;
    logic [2:0]  sym;
    logic [5:0]  count;

    prompt_decoder #(.STRING_W(64)) dut (
        .clock(clock), .reset(reset), .start(start), .bstring(bstring), .sym_ready(sym_ready),
        .sym_valid(sym_valid), .sym(sym), .busy(busy), .done(done), .error(error), .count(count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    int   obs_syms[$];
    int   obs_vcyc[$];
    logic obs_done, obs_err, timeout;
    logic [5:0] obs_count;
    int   obs_end, obs_unstable, obs_overlap, obs_busy_bad;

    int exp_syms[$];
    bit exp_err;
    int exp_l;

    // walk the string from the MSB: skip leading zeros, then split into runs of ones closed by a zero
    function automatic void model(input logic [63:0] bs);
        int i, ones;
        exp_syms.delete();
        exp_err = 0;
        i = 63;
        while (i >= 0 && !bs[i]) i--;
        exp_l = 63 - i;
        while (i >= 0) begin
            ones = 0;
            while (i >= 0 && bs[i] && ones < 5) begin
                ones++;
                i--;
            end
            if (ones == 0 || ones == 5 || i < 0) begin
                exp_err = 1;
                break;
            end
            exp_syms.push_back(ones);
            i--;
            if ((bs << (63 - i)) == 64'd0) break;
        end
    endfunction

    function automatic longint hash_obs();
        longint r = 0;
        foreach (obs_syms[i]) r = r * 7 + longint'(obs_syms[i]);
        return r;
    endfunction

    function automatic longint hash_exp();
        longint r = 0;
        foreach (exp_syms[i]) r = r * 7 + longint'(exp_syms[i]);
        return r;
    endfunction

    function automatic int exp_end();
        int s = exp_l + 3;
        foreach (exp_syms[i]) s += exp_syms[i] + 2;
        return s;
    endfunction

    function automatic logic [63:0] gen();
        logic [63:0] s = '0;
        int bits = 0;
        int n = $urandom_range(1, 14);
        if ($urandom_range(7) == 0) return {$urandom, $urandom};
        for (int j = 0; j < n; j++) begin
            int k = $urandom_range(1, 4);
            if (bits + k + 1 > 64) break;
            s = (s << (k + 1)) | (((64'd1 << k) - 64'd1) << 1);
            bits += k + 1;
        end
        s = s << $urandom_range(0, 64 - bits);
        if ($urandom_range(3) == 0) s ^= 64'd1 << $urandom_range(0, 63);
        return s;
    endfunction

    // runs one decode; cycle n counts rising edges after the edge that took start
    task automatic drive(input logic [63:0] bs, input int pct, input int hold);
        logic held = 1'b0;
        logic [2:0] hs = '0;
        int low_left = hold;
        obs_syms.delete();
        obs_vcyc.delete();
        obs_done = 0; obs_err = 0; timeout = 1; obs_count = '0;
        obs_end = 0; obs_unstable = 0; obs_overlap = 0; obs_busy_bad = 0;
        @(negedge clock);
        bstring = bs;
        start = 1'b1;
        sym_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        bstring = {$urandom, $urandom};
        for (int cyc = 1; cyc < 600; cyc++) begin
            if (cyc == 1 && busy !== 1'b1) obs_busy_bad++;
            if (int'(sym_valid) + int'(done) + int'(error) > 1) obs_overlap++;
            if (held && (sym_valid !== 1'b1 || sym !== hs)) obs_unstable++;
            if (done === 1'b1 || error === 1'b1) begin
                obs_done = done;
                obs_err = error;
                obs_end = cyc;
                obs_count = count;
                if (busy !== 1'b0) obs_busy_bad++;
                timeout = 0;
                break;
            end
            if (sym_valid === 1'b1) begin
                if (!held) obs_vcyc.push_back(cyc);
                if (low_left > 0) begin
                    sym_ready = 1'b0;
                    low_left--;
                end else begin
                    sym_ready = $urandom_range(99) < pct;
                end
                if (sym_ready) obs_syms.push_back(int'(sym));
                held = !sym_ready;
                hs = sym;
            end else begin
                held = 1'b0;
                sym_ready = $urandom_range(99) < pct;
            end
            start = cyc == 4 && busy === 1'b1;
            if (start) bstring = {$urandom, $urandom};
            @(negedge clock);
        end
        start = 1'b0;
        sym_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        bstring = 64'h16;
        repeat (2) @(negedge clock);
        tests++;
        if ({sym_valid, sym, busy, done, error, count} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs got %b exp 0", {sym_valid, sym, busy, done, error, count});
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_start_ignored busy got %b exp 0", busy);
        end
    endtask

    task automatic test_directed();
        drive(64'h16, 100, 0);
        tests++;
        if (obs_syms.size() != 2 || obs_syms[0] != 1 || obs_syms[1] != 2) begin
            fails++;
            $display("FAIL x16_syms got n=%0d hash=%0d exp 1,2", obs_syms.size(), hash_obs());
        end
        tests++;
        if (obs_done !== 1'b1 || obs_err !== 1'b0 || obs_count !== 6'd2 || timeout) begin
            fails++;
            $display("FAIL x16_end got done=%b err=%b count=%0d exp done=1 err=0 count=2", obs_done, obs_err, obs_count);
        end
        tests++;
        if (obs_vcyc.size() == 0 || obs_vcyc[0] != 63 || obs_end != 69) begin
            fails++;
            $display("FAIL x16_timing got first=%0d end=%0d exp first=63 end=69", obs_vcyc.size() ? obs_vcyc[0] : -1, obs_end);
        end
        drive(64'h1EE, 100, 10);
        tests++;
        if (obs_syms.size() != 2 || obs_syms[0] != 4 || obs_syms[1] != 3 || obs_unstable != 0) begin
            fails++;
            $display("FAIL x1ee_syms got n=%0d hash=%0d unstable=%0d exp 4,3 stable", obs_syms.size(), hash_obs(), obs_unstable);
        end
        tests++;
        if (obs_vcyc.size() != 2 || obs_vcyc[0] != 62 || obs_vcyc[1] != 77) begin
            fails++;
            $display("FAIL x1ee_hold got n=%0d first=%0d exp first=62 second=77", obs_vcyc.size(), obs_vcyc.size() ? obs_vcyc[0] : -1);
        end
        tests++;
        if (obs_done !== 1'b1 || obs_count !== 6'd2) begin
            fails++;
            $display("FAIL x1ee_end got done=%b count=%0d exp done=1 count=2", obs_done, obs_count);
        end
        drive(64'h0, 100, 0);
        tests++;
        if (obs_done !== 1'b1 || obs_end != 3 || obs_count !== 6'd0 || obs_vcyc.size() != 0) begin
            fails++;
            $display("FAIL zero_string got done=%b end=%0d count=%0d valids=%0d exp done=1 end=3 count=0 valids=0", obs_done, obs_end, obs_count, obs_vcyc.size());
        end
        drive(64'h3F, 100, 0);
        tests++;
        if (obs_err !== 1'b1 || obs_done !== 1'b0 || obs_count !== 6'd0 || obs_vcyc.size() != 0) begin
            fails++;
            $display("FAIL x3f_error got err=%b done=%b count=%0d valids=%0d exp err=1 count=0", obs_err, obs_done, obs_count, obs_vcyc.size());
        end
        drive(64'h5, 100, 0);
        tests++;
        if (obs_err !== 1'b1 || obs_count !== 6'd1 || obs_syms.size() != 1 || obs_syms[0] != 1) begin
            fails++;
            $display("FAIL x5_error got err=%b count=%0d n=%0d exp err=1 count=1 sym 1", obs_err, obs_count, obs_syms.size());
        end
    endtask

    task automatic test_reset_in_emit();
        int n = 0;
        @(negedge clock);
        bstring = 64'h16;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        sym_ready = 1'b1;
        for (int c = 0; c < 200 && n < 2; c++) begin
            if (sym_valid === 1'b1) n++;
            if (n == 2) begin
                reset = 1'b1;
                start = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        tests++;
        if (n != 2) begin
            fails++;
            $display("FAIL reset_emit_reach got symbols=%0d exp 2", n);
        end
        @(negedge clock);
        tests++;
        if ({sym_valid, sym, busy, done, error, count} !== 13'd0) begin
            fails++;
            $display("FAIL reset_emit_outputs got %b exp 0", {sym_valid, sym, busy, done, error, count});
        end
        reset = 1'b0;
        start = 1'b0;
        sym_ready = 1'b0;
        drive(64'h2, 100, 0);
        tests++;
        if (obs_done !== 1'b1 || obs_count !== 6'd1 || obs_syms.size() != 1 || obs_syms[0] != 1) begin
            fails++;
            $display("FAIL reset_emit_restart got done=%b count=%0d n=%0d exp done=1 count=1 sym 1", obs_done, obs_count, obs_syms.size());
        end
    endtask

    task automatic test_boundary();
        logic [63:0] vec[4];
        vec[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        vec[1] = 64'hF7BD_EF7B_DEF7_BDEE;
        vec[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        vec[3] = 64'h3;
        foreach (vec[v]) begin
            model(vec[v]);
            drive(vec[v], 100, 0);
            tests++;
            if (obs_syms.size() != exp_syms.size() || hash_obs() != hash_exp() || obs_count !== 6'(exp_syms.size())) begin
                fails++;
                $display("FAIL boundary_syms[%0d] got n=%0d count=%0d exp n=%0d", v, obs_syms.size(), obs_count, exp_syms.size());
            end
            tests++;
            if (obs_err !== exp_err || obs_done !== !exp_err || timeout) begin
                fails++;
                $display("FAIL boundary_end[%0d] got err=%b done=%b exp err=%b", v, obs_err, obs_done, exp_err);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            logic [63:0] bs = gen();
            int pct = $urandom_range(1) ? 100 : $urandom_range(30, 99);
            model(bs);
            drive(bs, pct, 0);
            tests++;
            if (obs_syms.size() != exp_syms.size() || hash_obs() != hash_exp()) begin
                fails++;
                $display("FAIL random_syms bs=%h got n=%0d hash=%0d exp n=%0d hash=%0d", bs, obs_syms.size(), hash_obs(), exp_syms.size(), hash_exp());
            end
            tests++;
            if (obs_err !== exp_err || obs_done !== !exp_err || timeout || obs_count !== 6'(exp_syms.size())) begin
                fails++;
                $display("FAIL random_end bs=%h got err=%b done=%b count=%0d exp err=%b count=%0d", bs, obs_err, obs_done, obs_count, exp_err, exp_syms.size());
            end
            tests++;
            if (obs_overlap != 0 || obs_unstable != 0 || obs_busy_bad != 0) begin
                fails++;
                $display("FAIL random_protocol bs=%h got overlap=%0d unstable=%0d busy_bad=%0d exp 0", bs, obs_overlap, obs_unstable, obs_busy_bad);
            end
            if (exp_syms.size() > 0) begin
                tests++;
                if (obs_vcyc.size() == 0 || obs_vcyc[0] != exp_l + exp_syms[0] + 3) begin
                    fails++;
                    $display("FAIL random_first bs=%h got %0d exp %0d", bs, obs_vcyc.size() ? obs_vcyc[0] : -1, exp_l + exp_syms[0] + 3);
                end
                if (pct == 100 && !exp_err) begin
                    tests++;
                    if (obs_end != exp_end()) begin
                        fails++;
                        $display("FAIL random_done_time bs=%h got %0d exp %0d", bs, obs_end, exp_end());
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a = 64'h0000_0000_0000_F7BA;
        logic [63:0] b = 64'h0000_0000_0000_0016;
        drive(a, 100, 0);
        model(b);
        drive(b, 100, 0);
        tests++;
        if (obs_done !== 1'b1 || obs_count !== 6'd2 || obs_end != exp_end() || hash_obs() != hash_exp()) begin
            fails++;
            $display("FAIL back_to_back got done=%b count=%0d end=%0d exp done=1 count=2 end=%0d", obs_done, obs_count, obs_end, exp_end());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_in_emit();
        test_boundary();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
